pipelined_adder: RTL and testbench
==================================

PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; legal range 1..64.
REQ-002 Parameter STAGES, default 4, number of pipeline stages; legal range 1..WIDTH; WIDTH SHALL be divisible by STAGES.
REQ-003 Illegal parameter combinations SHALL cause an elaboration-time error.
REQ-004 Port clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 Port in_valid  input  1  operands a, b, cin, sub present.
REQ-007 Port in_ready  output  1  block accepts an operation this cycle.
REQ-008 Port a  input  WIDTH  operand A.
REQ-009 Port b  input  WIDTH  operand B.
REQ-010 Port cin  input  1  carry-in (borrow-in when sub=1).
REQ-011 Port sub  input  1  0 = add, 1 = subtract.
REQ-012 Port out_valid  output  1  result present.
REQ-013 Port out_ready  input  1  downstream accepts the result.
REQ-014 Port sum  output  WIDTH  result.
REQ-015 Port cout  output  1  carry out of MSB (sub=1: 1 = no borrow).
REQ-016 Port ovf  output  1  two's-complement signed overflow.

Function
REQ-017 Transfer in SHALL occur when in_valid & in_ready; transfer out SHALL occur when out_valid & out_ready.
REQ-018 Effective operand SHALL be b ^ {WIDTH{sub}}; effective carry-in SHALL be cin ^ sub; sub=1, cin=0 yields a-b; sub=1, cin=1 yields a-b-1.
REQ-019 {cout, sum} SHALL equal a + b_eff + cin_eff, computed modulo 2^(WIDTH+1).
REQ-020 ovf SHALL equal carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
REQ-021 Slice width SHALL be W = WIDTH/STAGES; stage k SHALL add bits [k*W +: W] using the registered carry from stage k-1.
REQ-022 Stage k SHALL carry forward, unmodified, the operand bits of slices above k.
REQ-023 Stage k SHALL carry forward the result bits already computed for slices below k.
REQ-024 Each stage SHALL hold a valid flag.
REQ-025 Latency SHALL be exactly STAGES cycles from input transfer to out_valid with no backpressure; STAGES=1 gives a single registered stage.
REQ-026 Stage k SHALL load when it is empty or stage k+1 loads that cycle; the last stage advances when out_ready=1 or it is empty.
REQ-027 Each stage's valid flag SHALL propagate and bubbles SHALL collapse.
REQ-028 in_ready SHALL be combinational: stage 0 empty, or stage 0 advancing.
REQ-029 Throughput SHALL be one operation per cycle while out_ready=1.
REQ-030 While out_valid=1 and out_ready=0, sum, cout and ovf SHALL hold stable and no result SHALL be dropped or duplicated.
REQ-031 With all STAGES stages full and out_ready=0, in_ready SHALL be 0.
REQ-032 Simultaneous input and output transfer when full SHALL be accepted in the same cycle (in_ready=1 when out_ready=1).
REQ-033 Results SHALL exit in acceptance order.
REQ-034 When out_valid=0, sum, cout and ovf values are don't-care for the consumer but SHALL NOT be X after reset.

Reset
REQ-035 rst_n=0 SHALL asynchronously clear all stage valid flags, data registers and carry registers to 0.
REQ-036 During reset: out_valid=0, sum=0, cout=0, ovf=0.
REQ-037 On the first cycle after reset release, in_ready=1.
REQ-038 Reset mid-operation SHALL discard all in-flight operations; no result from before reset SHALL appear after release.

Verification
REQ-039 Config WIDTH=8, STAGES=2, out_ready=1: a=0xFF, b=0x01, cin=0, sub=0 -> 2 cycles later sum=0x00, cout=1, ovf=0.
REQ-040 a=0x7F, b=0x01, sub=0 -> sum=0x80, cout=0, ovf=1.
REQ-041 Subtract: a=0x05, b=0x07, cin=0, sub=1 -> sum=0xFE, cout=0 (borrow), ovf=0.
REQ-042 Subtract with borrow-in: a=0x80, b=0x01, cin=1, sub=1 -> sum=0x7E, cout=1, ovf=1.
REQ-043 Backpressure: stream 5 ops back-to-back with out_ready=0 for 4 cycles -> in_ready falls after 2 accepts, outputs hold, all 5 results emerge in order with none lost after out_ready=1.
REQ-044 Reset pulse with 2 ops in flight -> out_valid=0 immediately; after release no stale result appears and in_ready=1.
REQ-045 Randomized check against a reference model for STAGES in {1, 2, 8} at WIDTH=8 and STAGES in {1, 4, 32} at WIDTH=32, with random in_valid/out_ready.

Source files
------------

// File: rtl/pipelined_adder.sv
// Ripple-carry adder/subtractor split into STAGES equal slices, one slice per
// register stage, with a valid/ready handshake on both ends and collapsing bubbles.
module pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SAFE_STAGES = (STAGES > 0) ? STAGES : 1;
    localparam int SW          = WIDTH / SAFE_STAGES;
    localparam int LAST        = SAFE_STAGES - 1;

    if ((WIDTH < 1) || (WIDTH > 64) || (STAGES < 1) || (STAGES > WIDTH) ||
        ((WIDTH % SAFE_STAGES) != 0)) begin : g_param_check
        $error("pipelined_adder: illegal WIDTH=%0d / STAGES=%0d", WIDTH, STAGES);
    end

    logic [SAFE_STAGES-1:0] vld_q;
    logic [SAFE_STAGES-1:0] c_q;
    logic [SAFE_STAGES-1:0] load;
    logic [WIDTH-1:0]       a_q [SAFE_STAGES];
    logic [WIDTH-1:0]       b_q [SAFE_STAGES];
    logic [WIDTH-1:0]       s_q [SAFE_STAGES];

    for (genvar k = 0; k < SAFE_STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] src_a;
        logic [WIDTH-1:0] src_b;
        logic [WIDTH-1:0] src_s;
        logic [WIDTH-1:0] merged;
        logic             src_c;
        logic             src_v;
        logic [SW:0]      part;

        if (k == 0) begin : g_head
            // Subtraction folds into the adder: invert b and the carry-in once, up front.
            assign src_a = a;
            assign src_b = b ^ {WIDTH{sub}};
            assign src_s = '0;
            assign src_c = cin ^ sub;
            assign src_v = in_valid;
        end else begin : g_body
            assign src_a = a_q[k-1];
            assign src_b = b_q[k-1];
            assign src_s = s_q[k-1];
            assign src_c = c_q[k-1];
            assign src_v = vld_q[k-1];
        end

        assign part = {1'b0, src_a[k*SW +: SW]} + {1'b0, src_b[k*SW +: SW]} +
                      {{SW{1'b0}}, src_c};

        // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
        always_comb begin
            merged                = src_s;
            merged[k*SW +: SW]    = part[SW-1:0];
        end

        // Unrolled form of "empty, or the next stage loads": any hole at or
        // downstream of k lets k advance, and so does a draining output.
        assign load[k] = out_ready | ~(&vld_q[LAST:k]);

        // NOTE: sequential state uses non-blocking assignments so all stages update from pre-edge values.
        // NOTE: data registers are reset too, so sum/cout/ovf are never X after reset.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q[k] <= 1'b0;
                c_q[k]   <= 1'b0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                s_q[k]   <= '0;
            end else if (load[k]) begin
                vld_q[k] <= src_v;
                if (src_v) begin
                    c_q[k] <= part[SW];
                    a_q[k] <= src_a;
                    b_q[k] <= src_b;
                    s_q[k] <= merged;
                end
            end
        end
    end

    assign in_ready  = load[0];
    assign out_valid = vld_q[LAST];
    assign sum       = s_q[LAST];
    assign cout      = c_q[LAST];
    // Carry into the MSB is recovered as a^b^sum at that bit; XOR with carry-out gives overflow.
    assign ovf       = a_q[LAST][WIDTH-1] ^ b_q[LAST][WIDTH-1] ^ s_q[LAST][WIDTH-1] ^ c_q[LAST];

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: directed cases on an 8-bit/2-stage instance, then
// random handshake traffic on six configurations against an arithmetic reference.
module tb_pipelined_adder;

    localparam int NDUT = 6;
    localparam int CW [NDUT] = '{8, 8, 8, 32, 32, 32};
    localparam int CS [NDUT] = '{1, 2, 8, 1, 4, 32};
    localparam int DIR = 1;
    localparam int QD  = 64;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              out_ready;
    logic              cin;
    logic              sub;
    logic [63:0]       a_in;
    logic [63:0]       b_in;
    logic [NDUT-1:0]   in_ready_o;
    logic [NDUT-1:0]   out_valid_o;
    logic [NDUT-1:0]   cout_o;
    logic [NDUT-1:0]   ovf_o;
    logic [63:0]       sum_o [NDUT];

    int n_tests = 0;
    int n_fail  = 0;

    logic [65:0] q_mem [NDUT][QD];
    int          q_head [NDUT];
    int          q_cnt  [NDUT];
    logic        hold_v [NDUT];
    logic [65:0] hold_val [NDUT];

    logic [7:0]  bp_a [5] = '{8'h11, 8'hF0, 8'h7F, 8'h80, 8'h3C};
    logic [7:0]  bp_b [5] = '{8'h22, 8'h20, 8'h7F, 8'h01, 8'hC4};
    logic [65:0] bp_exp [5];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar i = 0; i < NDUT; i++) begin : g_dut
        localparam int W = CW[i];
        logic [W-1:0] s;
        pipelined_adder #(.WIDTH(W), .STAGES(CS[i])) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid),
            .in_ready (in_ready_o[i]),
            .a        (a_in[W-1:0]),
            .b        (b_in[W-1:0]),
            .cin      (cin),
            .sub      (sub),
            .out_valid(out_valid_o[i]),
            .out_ready(out_ready),
            .sum      (s),
            .cout     (cout_o[i]),
            .ovf      (ovf_o[i])
        );
        assign sum_o[i] = 64'(s);
    end

    task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: unsigned sum for {cout,sum}, signed range test for overflow.
    function automatic logic [65:0] ref_add(input int w, input logic [63:0] av, input logic [63:0] bv,
                                            input logic ci, input logic su);
        longint m, ua, ub, c, u, half, sa, sb, sr;
        logic [65:0] r;
        m    = (longint'(1) << w) - 1;
        ua   = longint'(av) & m;
        ub   = longint'(su ? ~bv : bv) & m;
        c    = longint'(ci ^ su);
        u    = ua + ub + c;
        half = longint'(1) << (w - 1);
        sa   = (ua >= half) ? ua - (half << 1) : ua;
        sb   = (ub >= half) ? ub - (half << 1) : ub;
        sr   = sa + sb + c;
        r          = '0;
        r[63:0]    = 64'(u & m);
        r[64]      = ((u >> w) & 1) != 0;
        r[65]      = (sr >= half) || (sr < -half);
        return r;
    endfunction

    function automatic logic [65:0] result_of(input int i);
        return {ovf_o[i], cout_o[i], sum_o[i]};
    endfunction

    task automatic monitor(input int i);
        if (hold_v[i]) begin
            check($sformatf("hold_valid_d%0d", i), 66'(out_valid_o[i]), 66'(1'b1));
            check($sformatf("hold_value_d%0d", i), result_of(i), hold_val[i]);
        end
        if (out_valid_o[i] && out_ready) begin
            check($sformatf("occupancy_d%0d", i), 66'(q_cnt[i] > 0), 66'(1'b1));
            if (q_cnt[i] > 0) begin
                check($sformatf("result_d%0d", i), result_of(i), q_mem[i][q_head[i]]);
                q_head[i] = (q_head[i] + 1) % QD;
                q_cnt[i]--;
            end
        end
        if (in_valid && in_ready_o[i]) begin
            q_mem[i][(q_head[i] + q_cnt[i]) % QD] = ref_add(CW[i], a_in, b_in, cin, sub);
            q_cnt[i]++;
        end
        hold_v[i]   = out_valid_o[i] && !out_ready;
        hold_val[i] = result_of(i);
    endtask

    task automatic dir_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                          input logic ci, input logic su,
                          input logic [7:0] es, input logic ec, input logic eo);
        a_in = 64'(av); b_in = 64'(bv); cin = ci; sub = su;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, "_latency"}, 66'(out_valid_o[DIR]), 66'(1'b0));
        @(posedge clk); #1;
        check({tag, "_valid"}, 66'(out_valid_o[DIR]), 66'(1'b1));
        check({tag, "_sum"},   66'(sum_o[DIR]),       66'(es));
        check({tag, "_cout"},  66'(cout_o[DIR]),      66'(ec));
        check({tag, "_ovf"},   66'(ovf_o[DIR]),       66'(eo));
    endtask

    initial begin
        int acc;
        int got;
        bit drained;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        cin = 1'b0; sub = 1'b0; a_in = '0; b_in = '0;
        for (int i = 0; i < NDUT; i++) begin
            q_head[i] = 0; q_cnt[i] = 0; hold_v[i] = 1'b0; hold_val[i] = '0;
        end
        for (int i = 0; i < 5; i++) bp_exp[i] = ref_add(8, 64'(bp_a[i]), 64'(bp_b[i]), 1'b0, i[0]);

        #2;
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("reset_valid_d%0d", i), 66'(out_valid_o[i]), 66'(1'b0));
            check($sformatf("reset_sum_d%0d", i),   66'(sum_o[i]),       66'(1'b0));
            check($sformatf("reset_cout_d%0d", i),  66'(cout_o[i]),      66'(1'b0));
            check($sformatf("reset_ovf_d%0d", i),   66'(ovf_o[i]),       66'(1'b0));
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("release_in_ready", 66'(in_ready_o[DIR]), 66'(1'b1));

        dir_op("add_wrap",  8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        dir_op("add_ovf",   8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        dir_op("sub_borrow", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
        dir_op("sub_bin",   8'h80, 8'h01, 1'b1, 1'b1, 8'h7E, 1'b1, 1'b1);

        // Flush, then stream five ops into a stalled output.
        @(posedge clk); #1;
        out_ready = 1'b0; cin = 1'b0;
        acc = 0;
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1;
            a_in = 64'(bp_a[acc]); b_in = 64'(bp_b[acc]); sub = acc[0];
            #1;
            check($sformatf("bp_in_ready_c%0d", c), 66'(in_ready_o[DIR]), 66'(c < 2));
            if (c >= 2) begin
                check($sformatf("bp_hold_valid_c%0d", c), 66'(out_valid_o[DIR]), 66'(1'b1));
                check($sformatf("bp_hold_value_c%0d", c), result_of(DIR), bp_exp[0]);
            end
            if (in_ready_o[DIR]) acc++;
            @(posedge clk); #1;
        end
        check("bp_accepts", 66'(acc), 66'(2));

        out_ready = 1'b1;
        got = 0;
        for (int cyc = 0; cyc < 20 && got < 5; cyc++) begin
            in_valid = (acc < 5);
            if (acc < 5) begin
                a_in = 64'(bp_a[acc]); b_in = 64'(bp_b[acc]); sub = acc[0];
            end
            #1;
            if (cyc == 0) check("bp_full_in_ready", 66'(in_ready_o[DIR]), 66'(1'b1));
            if (out_valid_o[DIR]) begin
                check($sformatf("bp_order%0d", got), result_of(DIR), bp_exp[got]);
                got++;
            end
            if (in_valid && in_ready_o[DIR]) acc++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("bp_count", 66'(got), 66'(5));

        // Two ops in flight, then an asynchronous reset between clock edges.
        out_ready = 1'b0; sub = 1'b0;
        in_valid = 1'b1; a_in = 64'h12; b_in = 64'h34;
        @(posedge clk); #1;
        a_in = 64'h56; b_in = 64'h78;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("rst_inflight", 66'(out_valid_o[DIR]), 66'(1'b1));
        rst_n = 1'b0;
        #1;
        check("rst_async_valid", 66'(out_valid_o[DIR]), 66'(1'b0));
        check("rst_async_sum",   66'(sum_o[DIR]),       66'(1'b0));
        out_ready = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 66'(in_ready_o[DIR]), 66'(1'b1));
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            check($sformatf("rst_no_stale_c%0d", c), 66'(out_valid_o[DIR]), 66'(1'b0));
        end

        // Random traffic on every configuration.
        for (int cyc = 0; cyc < 1500; cyc++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            a_in = {$urandom, $urandom};
            b_in = {$urandom, $urandom};
            cin  = 1'($urandom_range(0, 1));
            sub  = 1'($urandom_range(0, 1));
            #1;
            for (int i = 0; i < NDUT; i++) monitor(i);
            @(posedge clk); #1;
        end

        in_valid = 1'b0; out_ready = 1'b1;
        drained = 1'b0;
        for (int cyc = 0; cyc < 100 && !drained; cyc++) begin
            #1;
            for (int i = 0; i < NDUT; i++) monitor(i);
            drained = 1'b1;
            for (int i = 0; i < NDUT; i++) if (q_cnt[i] != 0) drained = 1'b0;
            @(posedge clk); #1;
        end
        for (int i = 0; i < NDUT; i++)
            check($sformatf("drain_empty_d%0d", i), 66'(q_cnt[i]), 66'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
